// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset vector and bus layouts for the IF stage.
package fetch_unit_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned IF_TO_ID_WD = 33;
  localparam int unsigned BR_WD       = 33;
  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam bit          STOP        = 1'b1;
  localparam bit          NO_STOP     = 1'b0;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: decode redirect in, fetch bus out, instruction SRAM port.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic                   fetch_adel;

  modport master (
    input  br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata, fetch_adel
  );

  modport slave (
    output br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata, fetch_adel
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction SRAM driver and stall-safe redirect buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  fetch_unit_if.master       bus
);

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        adel_r;
  logic [31:0] next_pc;
  br_bus_t     br;

  assign br = br_bus_t'(bus.br_bus);

  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br.br_e)      next_pc = br.br_addr;
    else if (pend_v)  next_pc = pend_addr;
  end

  // A redirect seen while stalled is parked; a live one at release supersedes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC_P - 32'd4;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      adel_r    <= 1'b0;
    end else if (stall[0] == NO_STOP) begin
      pc_reg <= next_pc;
      ce_reg <= 1'b1;
      pend_v <= 1'b0;
      if (misaligned(next_pc)) adel_r <= 1'b1;
    end else if (br.br_e) begin
      pend_v    <= 1'b1;
      pend_addr <= br.br_addr;
    end
  end

  assign bus.if_to_id_bus    = {ce_reg, pc_reg};
  assign bus.inst_sram_en    = ce_reg;
  assign bus.inst_sram_wen   = '0;
  assign bus.inst_sram_addr  = pc_reg;
  assign bus.inst_sram_wdata = '0;
  assign bus.fetch_adel      = adel_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  int unsigned        errors = 0;
  int unsigned        checks = 0;

  fetch_unit_if bus_if ();

  fetch_unit #(.RESET_PC_P(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic e, input logic [31:0] a);
    bus_if.br_bus = {e, a};
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] a);
    chk(tag, {31'b0, bus_if.if_to_id_bus}, {31'b0, 1'b1, a});
    chk({tag, "_sram"}, {31'b0, bus_if.inst_sram_en, bus_if.inst_sram_addr}, {31'b0, 1'b1, a});
  endtask

  initial begin
    rst   = 1'b1;
    stall = '0;
    drive_br(1'b0, 32'h0);

    step;
    chk("rst_bus",   {31'b0, bus_if.if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    chk("rst_en",    {63'b0, bus_if.inst_sram_en}, 64'd0);
    chk("rst_adel",  {63'b0, bus_if.fetch_adel}, 64'd0);
    chk("wen_wdata", {28'b0, bus_if.inst_sram_wen, bus_if.inst_sram_wdata}, 64'd0);

    rst = 1'b0;
    step; chk_pc("seq0", 32'hBFC0_0000);
    step; chk_pc("seq1", 32'hBFC0_0004);
    step; chk_pc("seq2", 32'hBFC0_0008);

    drive_br(1'b1, 32'hBFC0_0100);
    step; chk_pc("br_take", 32'hBFC0_0100);
    drive_br(1'b0, 32'h0);
    step; chk_pc("br_next", 32'hBFC0_0104);

    drive_br(1'b1, 32'hBFC0_0010);
    step; chk_pc("br_to10", 32'hBFC0_0010);

    stall = 6'b000001;
    drive_br(1'b1, 32'hBFC0_0200);
    step; chk_pc("stall_c1", 32'hBFC0_0010);
    drive_br(1'b0, 32'h0);
    step; chk_pc("stall_c2", 32'hBFC0_0010);
    step; chk_pc("stall_c3", 32'hBFC0_0010);
    stall = '0;
    step; chk_pc("pend_apply", 32'hBFC0_0200);
    step; chk_pc("pend_next", 32'hBFC0_0204);

    stall = 6'b000001;
    drive_br(1'b1, 32'hBFC0_0300);
    step; chk_pc("two_br_a", 32'hBFC0_0204);
    drive_br(1'b1, 32'hBFC0_0400);
    step; chk_pc("two_br_b", 32'hBFC0_0204);
    drive_br(1'b0, 32'h0);
    stall = '0;
    step; chk_pc("newest_pend", 32'hBFC0_0400);

    stall = 6'b111111;
    drive_br(1'b1, 32'hBFC0_0600);
    step; chk_pc("pend600_hold", 32'hBFC0_0400);
    stall = 6'b111110;
    drive_br(1'b1, 32'hBFC0_0500);
    step; chk_pc("live_wins", 32'hBFC0_0500);
    drive_br(1'b0, 32'h0);
    step; chk_pc("pend_cleared", 32'hBFC0_0504);

    drive_br(1'b1, 32'hFFFF_FFFC);
    step; chk_pc("to_top", 32'hFFFF_FFFC);
    chk("adel_aligned", {63'b0, bus_if.fetch_adel}, 64'd0);
    drive_br(1'b0, 32'h0);
    step; chk_pc("wrap", 32'h0000_0000);
    step; chk_pc("wrap_next", 32'h0000_0004);

    drive_br(1'b1, 32'hBFC0_0102);
    step; chk_pc("misalign", 32'hBFC0_0102);
    chk("adel_set", {63'b0, bus_if.fetch_adel}, 64'd1);
    drive_br(1'b0, 32'h0);
    step; chk_pc("misalign_next", 32'hBFC0_0106);
    chk("adel_sticky", {63'b0, bus_if.fetch_adel}, 64'd1);

    stall = 6'b000001;
    drive_br(1'b1, 32'hBFC0_0700);
    step; chk_pc("pend700", 32'hBFC0_0106);
    drive_br(1'b0, 32'h0);
    rst = 1'b1;
    step;
    chk("rst2_bus",  {31'b0, bus_if.if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    chk("rst2_adel", {63'b0, bus_if.fetch_adel}, 64'd0);
    rst = 1'b0;
    step;
    chk("post_rst_stall", {31'b0, bus_if.if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    stall = '0;
    step; chk_pc("restart", 32'hBFC0_0000);
    step; chk_pc("restart_next", 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: the producer end of the fetch→decode interface.
- Owns the PC register and drives the synchronous instruction SRAM.
- Emits if_to_id_bus {ce, pc} to decode and consumes decode's br_bus {br_e, br_addr} redirect.
- Obeys stall[0]. Holds a pending-redirect buffer so that a branch resolved while fetch is stalled is never lost.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction.
- STALL_W, 6, stall bus width (`StallBus).
- IF_TO_ID_WD, 33, fetch→decode bus width.
- BR_WD, 33, redirect bus width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector. Bit 0 = fetch/PC stop (`Stop = 1).
- br_bus  in  BR_WD  {br_e[32], br_addr[31:0]}, combinational from decode.
- if_to_id_bus  out  IF_TO_ID_WD  {ce[32], pc[31:0]}.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  byte write enables; constant 4'b0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 32'b0.
- fetch_adel  out  1  sticky misaligned-fetch flag.

Behaviour:
- State registers:
  - pc_reg[31:0]
  - ce_reg
  - pend_v, pend_addr[31:0]: pending redirect
  - adel_r
- Outputs are direct from registers:
  - if_to_id_bus = {ce_reg, pc_reg}
  - inst_sram_en = ce_reg
  - inst_sram_addr = pc_reg
  - fetch_adel = adel_r
- SRAM is synchronous: data for inst_sram_addr returns next cycle. Decode registers if_to_id_bus in the same edge, so pc and rdata align.
- Reset (rst=1 at posedge):
  - pc_reg ← RESET_PC − 4 (32'hBFBF_FFFC)
  - ce_reg ← 0, pend_v ← 0, pend_addr ← 0, adel_r ← 0
  - While ce_reg=0, inst_sram_en=0 and the bus carries ce=0.
  - Reset mid-operation discards any pending redirect and the sticky flag.
- next_pc priority:
  1. br_e=1 → br_addr
  2. else pend_v=1 → pend_addr
  3. else pc_reg + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000)
- Not stalled (stall[0]=0, rst=0), at each posedge:
  - pc_reg ← next_pc, ce_reg ← 1, pend_v ← 0.
  - A live br_e overrides and drops a stale pending redirect.
- Stalled (stall[0]=1):
  - pc_reg and ce_reg hold; SRAM address stays stable.
  - If br_e=1: pend_v ← 1, pend_addr ← br_addr. The newest br_e overwrites an older pending one.
  - If br_e=0: pend_v and pend_addr hold.
- First fetch: the first non-stalled cycle after reset loads pc_reg = RESET_PC with ce_reg=1. Latency from reset release to first valid fetch is 1 cycle.
- Redirect latency: br_e sampled at edge N → inst_sram_addr = br_addr after edge N (stall permitting). A pending redirect is applied at the first non-stalled edge.
- Misaligned target: whenever pc_reg would be loaded with an address having [1:0]≠0:
  - adel_r ← 1 (sticky until rst).
  - The load still proceeds; exception handling is out of scope for this block.
- stall bits [5:1] are ignored; decode bubbling is decode's concern.

Decomposition:
- Shared defines header (lib/defines.vh) already holds StallBus, IF_TO_ID_WD, BR_WD, Stop/NoStop. Add RESET_PC there as `ResetPC`.
- Single flat module; no sub-module needed.

Test Plan:
- Reset, then 4 free cycles → inst_sram_addr sequence BFC00000, BFC00004, BFC00008, BFC0000C. ce=0 during the reset cycle, ce=1 from the first post-reset edge.
- br_e=1, br_addr=BFC00100 pulsed one cycle at pc=BFC00008, no stall → next addr BFC00100, then BFC00104.
- stall[0]=1 for 3 cycles at pc=BFC00010, br_e=1/br_addr=BFC00200 in the 1st stalled cycle only → addr holds BFC00010 for all 3 cycles, then BFC00200 on release.
- Two redirects during one stall (BFC00300, then BFC00400) → BFC00400 fetched on release. Live br_e=BFC00500 at the release edge with pending set → BFC00500 wins, pend_v cleared.
- Force pc to FFFFFFFC via redirect, no stall → next addr 00000000. Redirect to BFC00102 → fetch_adel=1 and stays 1 until rst.
- rst asserted while pend_v=1 → pc restarts at BFC00000 and the pending redirect is not applied.
